dffram_hs: RTL and testbench
============================

Name: dffram_hs

Overview:
- Parametrised successor of the 2048x32 byte-write DFF RAM. Width, depth and byte-lane count are all generic.
- Adds a valid/ready request/response handshake for the multicycle core memory interface.
- Adds a post-reset hardware clear sequence and defined handling of out-of-range addresses.
- Sits between the multicycle core's memory port and instruction/data storage.

Parameters:
- ADDRESS_LENGTH, 11, address width in bits.
- DATA_LENGTH, 32, data width in bits. Must be a multiple of 8. Byte lanes NB = DATA_LENGTH/8 (localparam).
- DEPTH, 2048, number of words. Must satisfy 1 <= DEPTH <= 2**ADDRESS_LENGTH.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RSTn  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_we  input  NB  byte write enables; all-zero means read.
- req_addr  input  ADDRESS_LENGTH  word address.
- req_wdata  input  DATA_LENGTH  write data; lane k = bits [8k+7:8k].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  DATA_LENGTH  read data of the accepted request.
- init_done  output  1  clear sequence finished; RAM usable.

Behaviour:
- Reset (RSTn low, asynchronous): req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, state=INIT, clear counter=0.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle writes all-zero to word[counter], then increments counter.
  - After writing word DEPTH-1, transitions to RUN. init_done=1 from the first RUN cycle, i.e. DEPTH cycles after RSTn release.
  - req_ready=0 throughout INIT.
- RUN:
  - req_ready = !rsp_valid || rsp_ready (combinational).
  - A request is accepted on a posedge where req_valid && req_ready.
  - Every accepted request, read or write, produces exactly one response.
- Write: at the accepting edge, lane k of word[req_addr] is updated with req_wdata lane k where req_we[k]=1. Other lanes are unchanged.
- Read data: rsp_rdata is the word contents before the accepting edge (read-first), unless DFFRAM_WRITE_FIRST_EN is defined.
- Latency: rsp_valid rises on the edge that accepts the request, so it is visible the cycle after req_valid&&req_ready.
- Response retirement: the response retires on an edge with rsp_valid && rsp_ready.
  - If a new request is accepted on the same edge, rsp_valid stays 1 and rsp_rdata takes the new value (back-to-back throughput of 1 request/cycle).
  - Otherwise rsp_valid goes to 0 and rsp_rdata keeps its last value.
- Backpressure: while rsp_valid && !rsp_ready, rsp_rdata is held stable, req_ready=0 and no request is accepted.
- Out of range (req_addr >= DEPTH): the write is ignored, rsp_rdata=0, and the response is still generated. No aliasing into valid words.
- Reset mid-operation: any pending response is dropped immediately (asynchronously). INIT restarts from word 0, so all prior contents are cleared.
- req_* inputs are ignored while req_ready=0.

Optional Feature:
- Macro: DFFRAM_WRITE_FIRST_EN.
- Defined: rsp_rdata is the merged post-write word, i.e. req_wdata on enabled lanes and old data on the rest. For out-of-range addresses it is still 0.
- Undefined (default): read-first; rsp_rdata is the old word and the write is invisible until the next access.
- Reads with req_we=0 behave identically either way.

Test Plan:
- Reset release, DEPTH=2048 -> init_done rises exactly 2048 cycles later; req_ready=0 before that; a read of 0x005 returns 0x00000000.
- Write 0xAABBCCDD, we=4'b1111, addr 0x010; then write 0x11223344, we=4'b0101, addr 0x010; then read 0x010 -> 0xAA22CC44. The second write's response is 0xAABBCCDD (macro undefined) or 0xAA22CC44 (macro defined).
- Back-to-back reads of 0x010 then 0x011 with rsp_ready=1 -> two consecutive cycles with rsp_valid=1 and the correct data; req_ready stays 1.
- Pending response, rsp_ready held 0 for 3 cycles while req_valid=1 -> rsp_rdata unchanged and req_ready=0; the next request is accepted only on the edge where rsp_ready=1.
- DEPTH=1536, ADDRESS_LENGTH=11: write 0xDEADBEEF to 0x700, then read 0x700 -> response 0x00000000, and word 0x300 is unchanged.
- RSTn pulsed low while rsp_valid=1 after writing 0x12345678 to 0x020 -> rsp_valid=0 immediately; init_done=0 until 2048 cycles after release; a read of 0x020 then returns 0x00000000.

Source files
------------

// File: rtl/dffram_hs.sv
// Parametrised byte-write DFF RAM with valid/ready request/response handshake and post-reset clear.
// Optional macro DFFRAM_WRITE_FIRST_EN: responses return the merged post-write word instead of the old word.
module dffram_hs #(
  parameter int ADDRESS_LENGTH = 11,
  parameter int DATA_LENGTH    = 32,
  parameter int DEPTH          = 2048
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [DATA_LENGTH/8-1:0]  req_we,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [DATA_LENGTH-1:0]    req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_LENGTH-1:0]    rsp_rdata,
  output logic                      init_done
);

  localparam int NB = DATA_LENGTH / 8;
  localparam logic [ADDRESS_LENGTH:0]   DEPTH_EXT = (ADDRESS_LENGTH + 1)'(DEPTH);
  localparam logic [ADDRESS_LENGTH-1:0] LAST_ADDR = ADDRESS_LENGTH'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                    state;
  logic [ADDRESS_LENGTH-1:0] clr_cnt;
  logic [DATA_LENGTH-1:0]    mem [DEPTH];

  logic                      accept;
  logic                      in_range;
  logic [DATA_LENGTH-1:0]    old_word;
  logic [DATA_LENGTH-1:0]    merged_word;
  logic [DATA_LENGTH-1:0]    rsp_next;

  assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  // Widened compare so DEPTH == 2**ADDRESS_LENGTH does not overflow.
  assign in_range  = {1'b0, req_addr} < DEPTH_EXT;
  assign old_word  = mem[req_addr];

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < NB; k++) begin
      if (req_we[k]) merged_word[8*k +: 8] = req_wdata[8*k +: 8];
    end
  end

`ifdef DFFRAM_WRITE_FIRST_EN
  assign rsp_next = in_range ? merged_word : '0;
`else
  assign rsp_next = in_range ? old_word : '0;
`endif

  // NOTE: the array has no reset branch; the INIT sweep clears it, keeping it a plain DFF/RAM array.
  always_ff @(posedge CLK) begin
    if (state == INIT) begin
      mem[clr_cnt] <= '0;
    end else if (accept && in_range && (|req_we)) begin
      mem[req_addr] <= merged_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
            clr_cnt   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_next;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_hs.sv
// Self-checking bench for dffram_hs: a DEPTH=2048 instance and a DEPTH=1536 instance checked against an array model.
module tb_dffram_hs;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [3:0]  req_we    [2];
  logic [10:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        init_done [2];

  logic [31:0] model [2][2048];
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  dffram_hs #(.ADDRESS_LENGTH(11), .DATA_LENGTH(32), .DEPTH(2048)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .init_done(init_done[0])
  );

  dffram_hs #(.ADDRESS_LENGTH(11), .DATA_LENGTH(32), .DEPTH(1536)) dut_short (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .init_done(init_done[1])
  );

  function automatic int depth_of(input int d);
    return (d == 0) ? 2048 : 1536;
  endfunction

  function automatic void clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2048; i++) model[d][i] = 32'h0;
  endfunction

  // One accepted request: apply the byte-lane write to the model and return the expected response word.
  function automatic logic [31:0] model_access(input int d, input logic [10:0] a,
                                               input logic [3:0] we, input logic [31:0] wd);
    int ai;
    logic [31:0] old_w, new_w;
    ai = a;
    if (ai >= depth_of(d)) return 32'h0;
    old_w = model[d][ai];
    new_w = old_w;
    for (int k = 0; k < 4; k++)
      if (we[k]) new_w[8*k +: 8] = wd[8*k +: 8];
    model[d][ai] = new_w;
`ifdef DFFRAM_WRITE_FIRST_EN
    return new_w;
`else
    return old_w;
`endif
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 4'h0;
      req_addr[d]  = 11'h0;
      req_wdata[d] = 32'h0;
      rsp_ready[d] = 1'b1;
    end
  endtask

  // Counts edges after RSTn release until each instance reports init_done.
  task automatic wait_init();
    int first [2];
    bit early [2];
    first = '{-1, -1};
    early = '{1'b0, 1'b0};
    for (int c = 1; c <= 2100; c++) begin
      @(posedge CLK); #1;
      for (int d = 0; d < 2; d++) begin
        if (first[d] < 0 && init_done[d] === 1'b1) first[d] = c;
        if (first[d] < 0 && req_ready[d] !== 1'b0) early[d] = 1'b1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (first[d] != depth_of(d)) begin
        miscompares++;
        $display("FAIL init_latency[%0d]: init_done after %0d cycles, want %0d", d, first[d], depth_of(d));
      end
      vectors++;
      if (early[d]) begin
        miscompares++;
        $display("FAIL init_ready[%0d]: req_ready was not 0 during INIT, want 0", d);
      end
    end
  endtask

  // Single request, response held for 'stall' cycles with rsp_ready=0, then retired.
  task automatic xact(input int d, input logic [10:0] addr, input logic [3:0] we,
                      input logic [31:0] wd, input int stall, input string name);
    logic [31:0] exp;
    int n;
    exp = model_access(d, addr, we, wd);
    req_valid[d] = 1'b1; req_addr[d] = addr; req_we[d] = we; req_wdata[d] = wd;
    rsp_ready[d] = (stall == 0);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
    vectors++;
    if (req_ready[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready: req_ready=%b, want 1", name, req_ready[d]);
    end
    @(posedge CLK); #1;
    req_valid[d] = 1'b0;
    vectors++;
    if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== exp) begin
      miscompares++;
      $display("FAIL %s rsp @%h: valid=%b data=%h, want valid=1 data=%h", name, addr, rsp_valid[d], rsp_rdata[d], exp);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK); #1;
      vectors++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== exp || req_ready[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold: valid=%b data=%h ready=%b, want 1 %h 0", name, rsp_valid[d], rsp_rdata[d], req_ready[d], exp);
      end
    end
    rsp_ready[d] = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== exp) begin
      miscompares++;
      $display("FAIL %s retire: valid=%b data=%h, want 0 %h", name, rsp_valid[d], rsp_rdata[d], exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTn = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || init_done[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: ready=%b valid=%b data=%h done=%b, want all 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], init_done[d]);
      end
    end
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    clear_model();
    wait_init();
    xact(0, 11'h005, 4'h0, 32'h0, 0, "read_after_init");
  endtask

  task automatic test_byte_write();
    xact(0, 11'h010, 4'b1111, 32'hAABBCCDD, 0, "write_full");
    xact(0, 11'h010, 4'b0101, 32'h11223344, 1, "write_lanes");
    xact(0, 11'h010, 4'b0000, 32'hFFFFFFFF, 0, "read_merged");
    vectors++;
    if (model[0][16] !== 32'hAA22CC44) begin
      miscompares++;
      $display("FAIL merged_word: model=%h, want aa22cc44", model[0][16]);
    end
    xact(0, 11'h011, 4'b1111, 32'h55667788, 2, "write_011");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    e1 = model_access(0, 11'h010, 4'h0, 32'h0);
    e2 = model_access(0, 11'h011, 4'h0, 32'h0);
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 4'h0; req_addr[0] = 11'h010;
    @(posedge CLK); #1;
    vectors++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e1 || req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: valid=%b data=%h ready=%b, want 1 %h 1", rsp_valid[0], rsp_rdata[0], req_ready[0], e1);
    end
    req_addr[0] = 11'h011;
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    vectors++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e2 || req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: valid=%b data=%h ready=%b, want 1 %h 1", rsp_valid[0], rsp_rdata[0], req_ready[0], e2);
    end
    @(posedge CLK); #1;
    vectors++;
    if (rsp_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_retire: valid=%b, want 0", rsp_valid[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e1, e2;
    e1 = model_access(0, 11'h010, 4'h0, 32'h0);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 4'h0; req_addr[0] = 11'h010;
    @(posedge CLK); #1;
    req_addr[0] = 11'h011; req_we[0] = 4'b1000; req_wdata[0] = 32'h0F0F0F0F;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e1 || req_ready[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b, want 1 %h 0", i, rsp_valid[0], rsp_rdata[0], req_ready[0], e1);
      end
      @(posedge CLK); #1;
    end
    e2 = model_access(0, 11'h011, 4'b1000, 32'h0F0F0F0F);
    rsp_ready[0] = 1'b1;
    #1;
    vectors++;
    if (req_ready[0] !== 1'b1 || rsp_rdata[0] !== e1) begin
      miscompares++;
      $display("FAIL bp_release: ready=%b data=%h, want 1 %h", req_ready[0], rsp_rdata[0], e1);
    end
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    vectors++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e2) begin
      miscompares++;
      $display("FAIL bp_next: valid=%b data=%h, want 1 %h", rsp_valid[0], rsp_rdata[0], e2);
    end
    @(posedge CLK); #1;
    xact(0, 11'h011, 4'h0, 32'h0, 0, "bp_readback");
  endtask

  task automatic test_out_of_range();
    xact(1, 11'h300, 4'hF, 32'hCAFEF00D, 0, "oor_base");
    xact(1, 11'h700, 4'hF, 32'hDEADBEEF, 0, "oor_write");
    xact(1, 11'h700, 4'h0, 32'h0, 0, "oor_read");
    xact(1, 11'h300, 4'h0, 32'h0, 0, "oor_alias");
    xact(1, 11'h5FF, 4'hF, 32'h01020304, 0, "last_write");
    xact(1, 11'h5FF, 4'h0, 32'h0, 0, "last_read");
    xact(1, 11'h600, 4'h0, 32'h0, 1, "first_oor");
  endtask

  task automatic test_random();
    logic [10:0] a;
    for (int i = 0; i < 150; i++) begin
      a = 11'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = 11'h7FF;
      xact(0, a, 4'($urandom), $urandom, $urandom_range(0, 2), "rand0");
    end
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: a = 11'd1535;
        1: a = 11'd1536;
        2: a = 11'($urandom_range(1536, 2047));
        default: a = 11'($urandom_range(0, 7));
      endcase
      xact(1, a, 4'($urandom), $urandom, $urandom_range(0, 1), "rand1");
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] dummy;
    dummy = model_access(0, 11'h020, 4'hF, 32'h12345678);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 4'hF; req_addr[0] = 11'h020; req_wdata[0] = 32'h12345678;
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    vectors++;
    if (rsp_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_pending: valid=%b, want 1", rsp_valid[0]);
    end
    #2 RSTn = 1'b0;
    #1;
    vectors++;
    if (rsp_valid[0] !== 1'b0 || init_done[0] !== 1'b0 || rsp_rdata[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL midop_async: valid=%b done=%b data=%h, want 0 0 0", rsp_valid[0], init_done[0], rsp_rdata[0]);
    end
    idle_inputs();
    @(posedge CLK); #1;
    RSTn = 1'b1;
    clear_model();
    wait_init();
    xact(0, 11'h020, 4'h0, 32'h0, 0, "midop_cleared");
    xact(1, 11'h300, 4'h0, 32'h0, 0, "midop_cleared_short");
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
